dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised successor to the single 16-bit D flip-flop: a chain of `DEPTH` n-bit registers, each with a valid bit.
- Elastic ready/valid handshake with backpressure, plus global enable, synchronous set-to-ones and flush.
- Used as the inter-stage pipeline register and delay line in the CPU datapath, replacing hand-chained flip-flops.

Parameters:
- n, 16, data width in bits (n >= 1)
- DEPTH, 4, number of register stages (DEPTH >= 1)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  global clock enable; low = freeze all state
- set  input  1  synchronous; loads all-ones into every stage's data
- flush  input  1  synchronous; invalidates every stage
- in_valid  input  1  upstream data valid
- in_ready  output  1  stage 0 can accept this cycle
- in_data  input  n  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts this cycle
- out_data  output  n  last stage data

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- State: `data[i]` (n bits) and `valid[i]` for i = 0..DEPTH-1. Stage DEPTH-1 drives the outputs.
- Reset (`reset`=1 at the clk edge): all `valid[i]`=0 and all `data[i]`=0.
  - Reset overrides `enable`, `flush` and `set`.
  - After reset: out_valid=0, out_data=0, in_ready=1 (when enable=1).
- Priority at each edge: reset > enable low (hold) > flush > set > normal transfer.
- enable=0:
  - No state changes.
  - in_ready=0 and out_valid=0 (both gated combinationally).
  - out_data shows `data[DEPTH-1]` (macro off).
- flush=1 (enable=1):
  - All `valid[i]`=0; data unchanged.
  - An in_valid beat presented in the same cycle is dropped.
  - in_ready follows the normal equation that cycle.
- set=1 (enable=1, flush=0):
  - All `data[i]` = all-ones; `valid[i]` unchanged.
  - No transfer occurs; in_ready=0 that cycle.
- Stage ready (combinational, computed from the last stage backwards):
  - `rdy[DEPTH-1]` = !valid[DEPTH-1] || out_ready
  - `rdy[i]` = !valid[i] || rdy[i+1]
  - in_ready = rdy[0] && enable && !set
- Normal transfer (enable=1, flush=0, set=0): for each stage with `rdy[i]`=1:
  - `valid[i]` <= valid of the source.
  - `data[i]` <= source data only if the source is valid; otherwise data is held.
  - Source for stage 0 is in_valid/in_data; for stage i>0 it is stage i-1.
  - Stages with `rdy[i]`=0 hold.
- Handshake:
  - A beat is accepted when in_valid && in_ready, and consumed when out_valid && out_ready.
  - in_valid may be dropped without penalty; the block never drops an accepted beat except on flush or reset.
- Latency and throughput:
  - Empty pipe, no backpressure: a beat accepted at edge k appears on out_valid/out_data after edge k+DEPTH-1 (DEPTH cycles of register delay).
  - Sustained throughput is 1 beat/cycle.
- Full pipe (all valid) with out_ready=0: in_ready=0, contents hold.
  - With out_ready=1 on a full pipe: in_ready=1 (pass-through chain), so the pipe shifts and accepts in the same cycle.
- Bubbles: an invalid stage is always ready, so a bubble collapses as upstream data advances into it.
- Simultaneous accept and consume on the same edge is legal; occupancy is unchanged.
- Reset mid-stream discards all in-flight beats; the first accept is allowed on the edge after reset deasserts.
- DEPTH=1: behaves as a single registered ready/valid stage with the same rules.

Optional Feature:
- Macro: `DFF_PIPE_TRISTATE_EN`.
- Defined: when enable=0, out_data is driven high-impedance ('z) on all n bits, for sharing a bus with other pipes. out_valid=0 as before.
- Undefined: out_data always drives `data[DEPTH-1]`; no tristate logic is generated.

Test Plan:
- Reset then stream: n=16, DEPTH=4, reset 1 cycle, then in_valid=1 with 0x0001..0x0008 on consecutive cycles, out_ready=1 -> out_valid rises after the 4th edge; out_data = 0x0001..0x0008 in order, one per cycle, none lost or duplicated.
- Backpressure: fill with 0xA000..0xA003 and hold out_ready=0 -> in_ready=0 once all 4 stages are valid and out_data holds 0xA000. Raise out_ready -> 0xA000, 0xA001, ... drain one per cycle and in_ready=1 the same cycle.
- Flush: 3 beats in flight, pulse flush for 1 cycle with in_valid=1, in_data=0x1234 -> the next cycle out_valid=0, all stages invalid, and 0x1234 never appears.
- Set: with 2 valid beats, pulse set -> those beats emerge as 0xFFFF, empty stages remain invalid, and in_ready=0 during the set cycle.
- Enable freeze: in mid-stream drop enable for 3 cycles -> in_ready=0, out_valid=0 and state unchanged. After enable returns, the sequence resumes intact; with `DFF_PIPE_TRISTATE_EN` defined, out_data = 16'hzzzz while enable=0.
- Reset priority: assert reset together with set=1, flush=1 and in_valid=1 -> the next cycle all outputs are 0, in_ready=1, and all stages are empty.

Source files
------------

// File: rtl/dff_pipe.sv
// Purpose : elastic DEPTH-stage pipeline register / delay line, n-bit data, valid bit per stage.
// Latency : DEPTH cycles from accept to out_valid when empty and unstalled; 1 beat/cycle sustained.
// Backpr. : ready ripples back combinationally from out_ready; a full pipe passes ready through when out_ready=1.
//
// Ports:
//   clk, reset              - single clock; synchronous active-high reset clears all state
//   enable                  - global enable; low freezes state and gates in_ready/out_valid low
//   set                     - loads all-ones into every stage's data, valid bits untouched, no transfer
//   flush                   - invalidates every stage, data untouched, incoming beat dropped
//   in_valid/in_ready/in_data    - upstream ready/valid channel into stage 0
//   out_valid/out_ready/out_data - downstream ready/valid channel from stage DEPTH-1
//
// Optional build macro: DFF_PIPE_TRISTATE_EN
//   defined   - out_data goes high-impedance while enable=0 (shared-bus use)
//   undefined - out_data always drives the last stage's data
module dff_pipe #(
    parameter int n     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         set,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data
);

    logic [n-1:0]     data_q  [DEPTH];
    logic [n-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    // Per-stage ready and the source feeding each stage.
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] src_vld;
    logic [n-1:0]     src_dat [DEPTH];

    // Stage 0 is fed from the input port, every other stage from its predecessor.
    always_comb begin
        src_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            src_dat[i] = '0;
        end
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = valid_q[i-1];
            src_dat[i] = data_q[i-1];
        end
    end

    // Ready is resolved from the output end backwards: a stage can take new
    // data if it is empty (bubble) or if everything downstream of it moves.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = !valid_q[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !valid_q[i] || rdy[i+1];
        end
    end

    // Next state. enable=0 falls through to the hold defaults.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (enable) begin
            if (flush) begin
                valid_d = '0;
            end else if (set) begin
                for (int i = 0; i < DEPTH; i++) begin
                    data_d[i] = '1;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        valid_d[i] = src_vld[i];
                        // Data only moves with a valid source, so a bubble
                        // passing through leaves the old value in place.
                        if (src_vld[i]) begin
                            data_d[i] = src_dat[i];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // set blocks acceptance for its cycle because it overrides the transfer.
    assign in_ready  = rdy[0] && enable && !set;
    assign out_valid = valid_q[DEPTH-1] && enable;

`ifdef DFF_PIPE_TRISTATE_EN
    assign out_data = enable ? data_q[DEPTH-1] : {n{1'bz}};
`else
    assign out_data = data_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Purpose : directed self-checking bench for dff_pipe (n=16, DEPTH=4).
// Latency : expectations hand-derived from the 4-cycle empty-pipe latency.
// Backpr. : exercises out_ready stalls, pass-through ready, flush, set, freeze, reset priority.
module tb_dff_pipe;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         set;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    dff_pipe #(
        .n     (N),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .set       (set),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        set       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'h0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);

        // Stream 1..8 with no backpressure: beat accepted at edge c shows after edge c+3.
        out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 8);
            in_data  = 16'(c + 1);
            #1;
            if (c < 8) check_eq("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            check_eq("stream_out_valid", 32'(out_valid), 32'((c >= 3) && (c < 11)));
            if ((c >= 3) && (c < 11)) check_eq("stream_out_data", 32'(out_data), 32'(c - 2));
        end
        in_valid = 1'b0;

        // Backpressure: fill four stages while the sink is stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(k);
            #1;
            check_eq("bp_fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_data = 16'hA004;
        for (int h = 0; h < 2; h++) begin
            #1;
            check_eq("bp_full_in_ready",  32'(in_ready),  32'd0);
            check_eq("bp_full_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_full_out_data",  32'(out_data),  32'hA000);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("bp_drain_in_ready",  32'(in_ready),  32'd1);
            check_eq("bp_drain_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_drain_out_data",  32'(out_data),  32'hA000 + 32'(k));
            tick();
        end
        check_eq("bp_empty_out_valid", 32'(out_valid), 32'd0);

        // Flush with three beats in flight and a new beat offered.
        push(16'hB001);
        push(16'hB002);
        push(16'hB003);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        #1;
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("flush_stays_empty", 32'(out_valid), 32'd0);
        end

        // Set with two valid beats at stages 0 and 1.
        out_ready = 1'b0;
        push(16'hC001);
        push(16'hC002);
        set      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hC003;
        #1;
        check_eq("set_in_ready", 32'(in_ready), 32'd0);
        tick();
        set       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("set_out_valid_0", 32'(out_valid), 32'd0);
        tick();
        check_eq("set_out_valid_a", 32'(out_valid), 32'd0);
        tick();
        check_eq("set_out_valid_b", 32'(out_valid), 32'd1);
        check_eq("set_out_data_b",  32'(out_data),  32'hFFFF);
        tick();
        check_eq("set_out_valid_c", 32'(out_valid), 32'd1);
        check_eq("set_out_data_c",  32'(out_data),  32'hFFFF);
        tick();
        check_eq("set_out_valid_d", 32'(out_valid), 32'd0);

        // Enable freeze with a full pipe D001..D004 and an offered beat.
        push(16'hD001);
        push(16'hD002);
        push(16'hD003);
        push(16'hD004);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hD005;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("frz_in_ready",  32'(in_ready),  32'd0);
            check_eq("frz_out_valid", 32'(out_valid), 32'd0);
`ifdef DFF_PIPE_TRISTATE_EN
            check_eq("frz_out_data",  32'(out_data),  {16'h0, 16'hzzzz});
`else
            check_eq("frz_out_data",  32'(out_data),  32'hD001);
`endif
            tick();
        end
        enable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k < 2);
            in_data  = 16'hD005 + 16'(k);
            #1;
            check_eq("resume_out_valid", 32'(out_valid), 32'(k < 6));
            if (k < 6) check_eq("resume_out_data", 32'(out_data), 32'hD001 + 32'(k));
            tick();
        end
        in_valid = 1'b0;

        // Reset beats set, flush and an offered beat; pipe must come back empty.
        push(16'hE001);
        push(16'hE002);
        reset    = 1'b1;
        set      = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hE003;
        tick();
        reset    = 1'b0;
        set      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rstp_out_valid", 32'(out_valid), 32'd0);
        check_eq("rstp_out_data",  32'(out_data),  32'h0);
        check_eq("rstp_in_ready",  32'(in_ready),  32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("rstp_stays_empty", 32'(out_valid), 32'd0);
        end
        push(16'hF001);
        tick();
        tick();
        check_eq("post_rst_early", 32'(out_valid), 32'd0);
        tick();
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_data",  32'(out_data),  32'hF001);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
